cordic_sincos: RTL



---
 rtl/cordic_sincos_if.sv | 21 ++
 rtl/cordic_sincos.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cordic_sincos_if.sv
// Valid/ready bundle between the angle source, the CORDIC engine
// and the rotation-matrix stage that consumes cos3/sin3.
interface cordic_sincos_if;
   logic [15:0] angle;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] cos3;
   logic [15:0] sin3;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output angle, in_valid, out_ready,
      input  in_ready, cos3, sin3, out_valid
   );

   modport slave (
      input  angle, in_valid, out_ready,
      output in_ready, cos3, sin3, out_valid
   );
endinterface

// File: rtl/cordic_sincos.sv
// Iterative CORDIC: signed Q4.12 angle in, Q4.12 cos/sin out,
// one micro-rotation per cycle, one angle in flight.
module cordic_sincos #(
   parameter int ITER = 14
) (
   input  logic            clk,
   input  logic            rst,
   cordic_sincos_if.slave  io
);

   typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

   localparam logic signed [15:0] PI  = 16'sd12868;
   localparam logic signed [15:0] HPI = 16'sd6434;
   localparam logic signed [19:0] K0  = 20'sd39797;

   state_t state_q, state_d;
   logic signed [19:0] x_q, x_d;
   logic signed [19:0] y_q, y_d;
   logic signed [19:0] z_q, z_d;
   logic [3:0] cnt_q, cnt_d;
   logic fin_q, fin_d;
   logic neg_q, neg_d;
   logic [15:0] cos_q, cos_d;
   logic [15:0] sin_q, sin_d;

   logic signed [15:0] a_in, a_clamp, a_fold;
   logic signed [19:0] xs, ys, at;
   logic fold_neg, dpos;

   function automatic logic signed [19:0] atan_tab(
      input logic [3:0] i
   );
      logic signed [19:0] v;
      case (i)
         4'd0:    v = 20'sd51472;
         4'd1:    v = 20'sd30386;
         4'd2:    v = 20'sd16055;
         4'd3:    v = 20'sd8150;
         4'd4:    v = 20'sd4091;
         4'd5:    v = 20'sd2047;
         4'd6:    v = 20'sd1024;
         4'd7:    v = 20'sd512;
         4'd8:    v = 20'sd256;
         4'd9:    v = 20'sd128;
         4'd10:   v = 20'sd64;
         4'd11:   v = 20'sd32;
         4'd12:   v = 20'sd16;
         4'd13:   v = 20'sd8;
         4'd14:   v = 20'sd4;
         default: v = 20'sd2;
      endcase
      return v;
   endfunction

   // Q4.16 -> Q4.12 with round-half-up, optional negate, clip to +-1.0
   function automatic logic [15:0] fmt_out(
      input logic signed [19:0] v,
      input logic               neg
   );
      logic signed [19:0] r;
      r = (v + 20'sd8) >>> 4;
      if (neg) r = -r;
      if (r > 20'sd4096) r = 20'sd4096;
      else if (r < -20'sd4096) r = -20'sd4096;
      return r[15:0];
   endfunction

   always_comb begin
      a_in = signed'(io.angle);
      a_clamp = a_in;
      if (a_in > PI) a_clamp = PI;
      else if (a_in < -PI) a_clamp = -PI;
      a_fold = a_clamp;
      fold_neg = 1'b0;
      if (a_clamp > HPI) begin
         a_fold = a_clamp - PI;
         fold_neg = 1'b1;
      end else if (a_clamp < -HPI) begin
         a_fold = a_clamp + PI;
         fold_neg = 1'b1;
      end
   end

   always_comb begin
      xs = x_q >>> cnt_q;
      ys = y_q >>> cnt_q;
      at = atan_tab(cnt_q);
      dpos = ~z_q[19];
   end

   always_comb begin
      state_d = state_q;
      x_d = x_q;
      y_d = y_q;
      z_d = z_q;
      cnt_d = cnt_q;
      fin_d = fin_q;
      neg_d = neg_q;
      cos_d = cos_q;
      sin_d = sin_q;
      unique case (state_q)
         IDLE: begin
            if (io.in_valid) begin
               state_d = ROT;
               x_d = K0;
               y_d = '0;
               z_d = signed'({a_fold, 4'h0});
               cnt_d = '0;
               fin_d = 1'b0;
               neg_d = fold_neg;
            end
         end
         ROT: begin
            if (!fin_q) begin
               x_d = dpos ? x_q - ys : x_q + ys;
               y_d = dpos ? y_q + xs : y_q - xs;
               z_d = dpos ? z_q - at : z_q + at;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'(ITER - 1)) fin_d = 1'b1;
            end else begin
               cos_d = fmt_out(x_q, neg_q);
               sin_d = fmt_out(y_q, neg_q);
               state_d = DONE;
            end
         end
         DONE: begin
            if (io.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         x_q <= '0;
         y_q <= '0;
         z_q <= '0;
         cnt_q <= '0;
         fin_q <= 1'b0;
         neg_q <= 1'b0;
         cos_q <= 16'h1000;
         sin_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         x_q <= x_d;
         y_q <= y_d;
         z_q <= z_d;
         cnt_q <= cnt_d;
         fin_q <= fin_d;
         neg_q <= neg_d;
         cos_q <= cos_d;
         sin_q <= sin_d;
      end
   end

   assign io.in_ready = (state_q == IDLE);
   assign io.out_valid = (state_q == DONE);
   assign io.cos3 = cos_q;
   assign io.sin3 = sin_q;

endmodule
